// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit sitting between the EX/MEM pipeline register and a
//   variable-latency data memory. It steers byte lanes, generates byte enables,
//   sign/zero-extends load data, flags misaligned and conflicting accesses, aborts
//   on memory timeout, and stalls the pipeline until each access completes.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   valid_i                    instruction present in MEM (held while stall_o=1)
//   MemRead_MEM, MemWrite_MEM  load / store request
//   address_MEM                byte address
//   size_i, sign_ext_i         0=byte 1=half 2=word 3=dword, load extension mode
//   Rd2_Reg_out_MEM            right-justified store data
//   ReadData_MEM               extended load result (held until next load completes)
//   done_o, err_o              completion pulse and status (00 ok, 01 misaligned,
//                              10 timeout, 11 read+write both set)
//   stall_o                    hold pipeline
//   mem_req .. mem_be          memory request side (aligned address, lane data)
//   mem_rdata, mem_ack         memory response side
//
// state  | meaning
// IDLE   | waiting for a load/store; accepts it combinationally (stall same cycle)
// REQ    | request on the memory bus, waiting for mem_ack or timeout
// DONE   | one-cycle completion pulse; held valid_i is not re-accepted here

module mem_access_unit #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  MemRead_MEM,
    input  logic                  MemWrite_MEM,
    input  logic [ADDR_W-1:0]     address_MEM,
    input  logic [1:0]            size_i,
    input  logic                  sign_ext_i,
    input  logic [DATA_W-1:0]     Rd2_Reg_out_MEM,
    output logic [DATA_W-1:0]     ReadData_MEM,
    output logic                  done_o,
    output logic [1:0]            err_o,
    output logic                  stall_o,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              sext_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        err_q;

    logic              accept;
    logic              misaligned;
    logic [ADDR_W-1:0] align_mask;
    logic              in_req;

    logic [DATA_W-1:0] wd_shift;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] rd_fmt;
    logic [BYTES-1:0]  lane_be;
    logic              sbit;

    // rst_n gates acceptance so every output, stall included, reads 0 during reset.
    assign accept = rst_n && (state == S_IDLE) && valid_i && (MemRead_MEM || MemWrite_MEM);

    // Sizes wider than the bus are treated as misaligned.
    assign align_mask = (ADDR_W'(1) << size_i) - ADDR_W'(1);
    assign misaligned = (|(address_MEM & align_mask)) || (int'(size_i) > OFF_W);

    assign in_req = (state == S_REQ);

    always_comb begin
        lane_be    = '0;
        lane_wdata = '0;
        rd_fmt     = '0;
        sbit       = 1'b0;
        wd_shift   = wdata_q << (8 * off_q);
        rd_shift   = mem_rdata >> (8 * off_q);
        for (int i = 0; i < BYTES; i++) begin
            if (i >= int'(off_q) && i < int'(off_q) + (1 << size_q)) begin
                lane_be[i]         = 1'b1;
                lane_wdata[8*i +: 8] = wd_shift[8*i +: 8];
            end
            // Bytes are visited low to high, so sbit is settled before the fill bytes.
            if (i < (1 << size_q)) begin
                rd_fmt[8*i +: 8] = rd_shift[8*i +: 8];
                if (i == (1 << size_q) - 1)
                    sbit = sext_q & rd_shift[8*i + 7];
            end else begin
                rd_fmt[8*i +: 8] = {8{sbit}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= '0;
            ReadData_MEM <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= MemWrite_MEM;
                        sext_q  <= sign_ext_i;
                        size_q  <= size_i;
                        off_q   <= address_MEM[OFF_W-1:0];
                        addr_q  <= address_MEM & ~ADDR_W'(BYTES - 1);
                        wdata_q <= Rd2_Reg_out_MEM;
                        cnt     <= CNT_W'(TIMEOUT);
                        if (MemRead_MEM && MemWrite_MEM) begin
                            err_q <= 2'b11;
                            state <= S_DONE;
                        end else if (misaligned) begin
                            err_q <= 2'b01;
                            state <= S_DONE;
                        end else begin
                            err_q <= 2'b00;
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Down-counter: the TIMEOUT-th REQ cycle without ack is terminal.
                    if (mem_ack) begin
                        if (!we_q)
                            ReadData_MEM <= rd_fmt;
                        err_q <= 2'b00;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else if (cnt == CNT_W'(1)) begin
                        if (!we_q)
                            ReadData_MEM <= '0;
                        err_q <= 2'b10;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o   = accept || in_req;
    assign done_o    = (state == S_DONE);
    assign err_o     = done_o ? err_q : 2'b00;
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_addr  = in_req ? addr_q : '0;
    assign mem_wdata = in_req ? lane_wdata : '0;
    assign mem_be    = in_req ? lane_be : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [63:0] address_MEM;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic [63:0] Rd2_Reg_out_MEM;
    logic [63:0] ReadData_MEM;
    logic        done_o;
    logic [1:0]  err_o;
    logic        stall_o;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    logic [63:0] rd_model;

    // results of the most recent op, for directed spot checks
    int          last_req_n;
    int          last_stall_n;
    int          last_done_n;
    logic [63:0] last_addr;
    logic [7:0]  last_be;
    logic [63:0] last_wdata;
    logic [1:0]  last_err;

    mem_access_unit #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .MemRead_MEM     (MemRead_MEM),
        .MemWrite_MEM    (MemWrite_MEM),
        .address_MEM     (address_MEM),
        .size_i          (size_i),
        .sign_ext_i      (sign_ext_i),
        .Rd2_Reg_out_MEM (Rd2_Reg_out_MEM),
        .ReadData_MEM    (ReadData_MEM),
        .done_o          (done_o),
        .err_o           (err_o),
        .stall_o         (stall_o),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] byte_mask(input int nb);
        return (128'd1 << (8 * nb)) - 128'd1;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input int size, input bit sext);
        int nb;
        int off;
        logic [127:0] m;
        logic [127:0] r;
        nb  = 1 << size;
        off = int'(addr[2:0]);
        m   = byte_mask(nb);
        r   = ({64'd0, rdata} >> (8 * off)) & m;
        if (sext && r[8*nb-1])
            r = r | ~m;
        return r[63:0];
    endfunction

    function automatic logic [7:0] exp_be(input logic [63:0] addr, input int size);
        int nb;
        nb = 1 << size;
        return 8'(((1 << nb) - 1) << int'(addr[2:0]));
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [63:0] data, input logic [63:0] addr,
                                              input int size);
        logic [127:0] w;
        w = ({64'd0, data} & byte_mask(1 << size)) << (8 * int'(addr[2:0]));
        return w[63:0];
    endfunction

    // Runs one access starting at a negedge; returns at the negedge after done_o.
    // ack_d: REQ cycle on which mem_ack is raised (0 = never, forcing a timeout).
    task automatic op(input bit rd, input bit wr, input logic [63:0] addr, input int size,
                      input bit sext, input logic [63:0] data, input int ack_d,
                      input logic [63:0] rdata);
        int   nb;
        int   cyc;
        int   req_n;
        int   st_n;
        int   done_n;
        bit   got;
        bit   st_done;
        bit   s_we;
        logic [1:0] e_err;
        int   e_lat;
        int   e_req;

        nb = 1 << size;
        if (rd && wr)                        e_err = 2'b11;
        else if ((addr & 64'(nb - 1)) != 0)  e_err = 2'b01;
        else if (ack_d == 0)                 e_err = 2'b10;
        else                                 e_err = 2'b00;
        e_req = (e_err == 2'b11 || e_err == 2'b01) ? 0 : (ack_d == 0 ? TO : ack_d);
        e_lat = e_req + 1;

        valid_i         = 1'b1;
        MemRead_MEM     = rd;
        MemWrite_MEM    = wr;
        address_MEM     = addr;
        size_i          = 2'(size);
        sign_ext_i      = sext;
        Rd2_Reg_out_MEM = data;
        mem_ack         = 1'b0;

        cyc = 0; req_n = 0; st_n = 0; done_n = -1; got = 1'b0; st_done = 1'b1; s_we = 1'b0;
        while (!got && cyc < 40) begin
            #1;
            if (stall_o) st_n++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    last_addr  = mem_addr;
                    last_be    = mem_be;
                    last_wdata = mem_wdata;
                    s_we       = mem_we;
                end
                mem_ack   = (req_n == ack_d);
                mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0;
            end
            if (done_o) begin
                got      = 1'b1;
                done_n   = cyc;
                last_err = err_o;
                st_done  = stall_o;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;

        if (!rd && !wr) begin
            // nothing
        end else if (e_err == 2'b00 && rd) begin
            rd_model = exp_load(rdata, addr, size, sext);
        end else if (e_err == 2'b10 && rd) begin
            rd_model = 64'd0;
        end

        last_req_n = req_n; last_stall_n = st_n; last_done_n = done_n;

        chk("done_seen",    64'(got), 64'd1);
        chk("latency",      64'(done_n), 64'(e_lat));
        chk("req_cycles",   64'(req_n), 64'(e_req));
        chk("stall_cycles", 64'(st_n), 64'(e_lat));
        chk("done_no_stall", 64'(st_done), 64'd0);
        chk("err",          64'(last_err), 64'(e_err));
        if (e_req > 0) begin
            chk("mem_addr", last_addr, addr & ~64'h7);
            chk("mem_be",   64'(last_be), 64'(exp_be(addr, size)));
            chk("mem_we",   64'(s_we), 64'(wr));
            if (wr)
                chk("mem_wdata", last_wdata, exp_wdata(data, addr, size));
        end
        chk("read_data", ReadData_MEM, rd_model);
    endtask

    // One idle cycle with a stray ack that must be ignored.
    task automatic idle_cycle();
        valid_i = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("idle_stall", 64'(stall_o), 64'd0);
        chk("idle_req",   64'(mem_req), 64'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_done", 64'(done_o), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] r;
        int sz;
        int k;
        int ad;
        bit rd;
        bit wr;

        rst_n = 1'b0; valid_i = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        address_MEM = '0; size_i = '0; sign_ext_i = 1'b0; Rd2_Reg_out_MEM = '0;
        mem_rdata = '0; mem_ack = 1'b0; rd_model = '0;

        #2;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_done",  64'(done_o), 64'd0);
        chk("rst_err",   64'(err_o), 64'd0);
        chk("rst_rdata", ReadData_MEM, 64'd0);
        chk("rst_be",    64'(mem_be), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // byte load with sign extension from lane 3
        op(1, 0, 64'h13, 0, 1, 64'd0, 1, 64'h0000_0000_8000_0000);
        chk("t1_addr",  last_addr, 64'h10);
        chk("t1_be",    64'(last_be), 64'h08);
        chk("t1_rdata", ReadData_MEM, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_lat",   64'(last_done_n), 64'd2);

        // half store into the top lanes, ack on third REQ cycle
        op(0, 1, 64'h06, 1, 0, 64'h1234, 3, 64'd0);
        chk("t2_be",    64'(last_be), 64'hC0);
        chk("t2_wdata", last_wdata, 64'h1234_0000_0000_0000);
        chk("t2_stall", 64'(last_stall_n), 64'd4);

        // misaligned word load bypasses the memory
        op(1, 0, 64'h02, 2, 0, 64'd0, 1, 64'h5555);
        chk("t3_req", 64'(last_req_n), 64'd0);
        chk("t3_err", 64'(last_err), 64'd1);
        chk("t3_lat", 64'(last_done_n), 64'd1);

        // dword load with no ack times out
        op(1, 0, 64'h40, 3, 0, 64'd0, 0, 64'hAAAA);
        chk("t4_req",   64'(last_req_n), 64'(TO));
        chk("t4_rdata", ReadData_MEM, 64'd0);

        // reset during REQ drops the request asynchronously
        valid_i = 1'b1; MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0;
        address_MEM = 64'h20; size_i = 2'd3; sign_ext_i = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_req_before", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_rst",   64'(mem_req), 64'd0);
        chk("t5_stall_rst", 64'(stall_o), 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_model = 64'd0;
        @(negedge clk);
        op(1, 0, 64'h18, 3, 0, 64'd0, 2, 64'hDEAD_BEEF_0000_0001);
        chk("t5_rdata", ReadData_MEM, 64'hDEAD_BEEF_0000_0001);

        // back-to-back: load, store, conflicting op, then another load
        op(1, 0, 64'h104, 2, 1, 64'd0, 1, 64'hF000_0000_1111_2222);
        op(0, 1, 64'h108, 3, 0, 64'h0123_4567_89AB_CDEF, 2, 64'd0);
        op(1, 1, 64'h110, 3, 0, 64'h77, 1, 64'h99);
        chk("t6_req", 64'(last_req_n), 64'd0);
        chk("t6_err", 64'(last_err), 64'd3);
        op(1, 0, 64'h201, 0, 0, 64'd0, 1, 64'h0000_0000_0000_C300);
        chk("t6_rdata", ReadData_MEM, 64'h0000_0000_0000_00C3);
        idle_cycle();

        // randomized mix
        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 9));
            rd = (k == 0) || (k < 5);
            wr = (k == 0) || (k >= 5);
            sz = int'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                a = a & ~64'((1 << sz) - 1);
            d  = {$urandom, $urandom};
            r  = {$urandom, $urandom};
            ad = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            op(rd, wr, a, sz, bit'($urandom_range(0, 1)), d, ad, r);
            if ($urandom_range(0, 2) == 0)
                idle_cycle();
        end

        valid_i = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
